// File: rtl/onchip_mem_arb_pkg.sv
// Shared constants and the arbiter state encoding for the on-chip RAM arbiter.
// BE_W is fixed by the RAM's 32-bit word with four byte lanes.
package onchip_mem_arb_pkg;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
  localparam int DEPTH  = 5120;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/onchip_mem_arb_rr.sv
// Round-robin grant FSM with burst holding for two masters.
// Handshake: req[n] is a pending request; grant[n] means it is accepted this cycle.
// The 'state' register is the FSM debug probe.
module onchip_mem_arb_rr
  import onchip_mem_arb_pkg::*;
#(
  parameter int HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  localparam int CNT_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

  arb_state_t       state, state_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
  logic             last_grant, last_grant_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      hold_cnt   <= hold_cnt_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    grant        = 2'b00;
    case (state)
      IDLE: begin
        hold_cnt_nxt = '0;
        if (req[0] && req[1]) begin
          if (last_grant) begin
            grant     = 2'b01;
            state_nxt = OWN0;
          end else begin
            grant     = 2'b10;
            state_nxt = OWN1;
          end
        end else if (req[0]) begin
          grant     = 2'b01;
          state_nxt = OWN0;
        end else if (req[1]) begin
          grant     = 2'b10;
          state_nxt = OWN1;
        end
      end
      OWN0: begin
        if (req[0]) begin
          if (req[1] && hold_cnt == CNT_LAST) begin
            grant        = 2'b10;
            state_nxt    = OWN1;
            hold_cnt_nxt = '0;
          end else begin
            grant = 2'b01;
            // Saturate so a lone requester keeps the port indefinitely.
            if (hold_cnt != CNT_LAST) hold_cnt_nxt = hold_cnt + 1'b1;
          end
        end else if (req[1]) begin
          grant        = 2'b10;
          state_nxt    = OWN1;
          hold_cnt_nxt = '0;
        end else begin
          state_nxt    = IDLE;
          hold_cnt_nxt = '0;
        end
      end
      OWN1: begin
        if (req[1]) begin
          if (req[0] && hold_cnt == CNT_LAST) begin
            grant        = 2'b01;
            state_nxt    = OWN0;
            hold_cnt_nxt = '0;
          end else begin
            grant = 2'b10;
            if (hold_cnt != CNT_LAST) hold_cnt_nxt = hold_cnt + 1'b1;
          end
        end else if (req[0]) begin
          grant        = 2'b01;
          state_nxt    = OWN0;
          hold_cnt_nxt = '0;
        end else begin
          state_nxt    = IDLE;
          hold_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt    = IDLE;
        hold_cnt_nxt = '0;
      end
    endcase
  end

  always_comb begin
    last_grant_nxt = last_grant;
    if (grant[1])      last_grant_nxt = 1'b1;
    else if (grant[0]) last_grant_nxt = 1'b0;
  end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Two-master Avalon-MM arbiter in front of the 5120x32 on-chip RAM (1-cycle read latency).
// Optional range checking is enabled by defining ONCHIP_MEM_ARB_BOUNDS_CHECK_EN.
module onchip_mem_arbiter
  import onchip_mem_arb_pkg::*;
#(
  parameter int HOLD_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic              bound_err
);

  logic [1:0]        req;
  logic [1:0]        grant;
  logic              any_grant;
  logic [ADDR_W-1:0] sel_address;
  logic [BE_W-1:0]   sel_byteenable;
  logic [DATA_W-1:0] sel_writedata;
  logic              sel_read;
  logic              sel_write;
  logic              oob;
  logic              acc_read;

  logic [ADDR_W-1:0] addr_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] wdata_q;
  logic              write_q;

  logic              rd_pend;
  logic              rd_owner;
  logic              rd_oob;
  logic [DATA_W-1:0] rd_data;

  assign req = {m1_read | m1_write, m0_read | m0_write};

  onchip_mem_arb_rr #(
    .HOLD_MAX (HOLD_MAX)
  ) u_rr (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .grant (grant)
  );

  assign any_grant      = |grant;
  assign m0_waitrequest = req[0] & ~grant[0];
  assign m1_waitrequest = req[1] & ~grant[1];

  assign sel_address    = grant[1] ? m1_address    : m0_address;
  assign sel_byteenable = grant[1] ? m1_byteenable : m0_byteenable;
  assign sel_writedata  = grant[1] ? m1_writedata  : m0_writedata;
  assign sel_read       = grant[1] ? m1_read       : m0_read;
  assign sel_write      = grant[1] ? m1_write      : m0_write;

  // A simultaneous read+write is treated as a write only.
  assign acc_read = any_grant & sel_read & ~sel_write;

`ifdef ONCHIP_MEM_ARB_BOUNDS_CHECK_EN
  assign oob = any_grant & (sel_address >= ADDR_W'(DEPTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    bound_err <= 1'b0;
    else if (oob) bound_err <= 1'b1;
  end
`else
  assign oob       = 1'b0;
  assign bound_err = 1'b0;
`endif

  // Idle cycles keep the RAM-side bus steady at the last granted access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else if (any_grant) begin
      addr_q  <= sel_address;
      be_q    <= sel_byteenable;
      wdata_q <= sel_writedata;
      write_q <= sel_write;
    end
  end

  assign mem_address    = any_grant ? sel_address    : addr_q;
  assign mem_byteenable = any_grant ? sel_byteenable : be_q;
  assign mem_writedata  = any_grant ? sel_writedata  : wdata_q;
  assign mem_write      = any_grant ? sel_write      : write_q;
  assign mem_chipselect = any_grant & ~oob;
  assign mem_clken      = 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
      rd_oob   <= 1'b0;
    end else begin
      rd_pend  <= acc_read;
      rd_owner <= grant[1];
      rd_oob   <= oob;
    end
  end

  assign rd_data          = rd_oob ? '0 : mem_readdata;
  assign m0_readdatavalid = rd_pend & ~rd_owner;
  assign m1_readdatavalid = rd_pend & rd_owner;
  assign m0_readdata      = m0_readdatavalid ? rd_data : '0;
  assign m1_readdata      = m1_readdatavalid ? rd_data : '0;

endmodule
